decode_regfile: RTL and testbench
=================================

Name: decode_regfile

Overview:
Decode-stage register file and load-use hazard unit. It sits directly upstream of the ID/EX pipeline register and drives its rs1_data_id / rs2_data_id inputs. It also generates the stall and bubble controls for the IF/ID register, the PC and the ID/EX register. Writeback results are written here and bypassed through to same-cycle reads.

Parameters:
- XLEN, 32, register data width.
- NREGS, 32, number of architectural registers; index width is log2(NREGS) = 5.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr_id  in  5  source register 1 index from the decoded instruction.
- rs2_addr_id  in  5  source register 2 index from the decoded instruction.
- uses_rs1_id  in  1  instruction in ID reads rs1.
- uses_rs2_id  in  1  instruction in ID reads rs2.
- rd_ex  in  5  destination index of the instruction currently in EX.
- load_ex  in  1  instruction in EX is a load.
- wb_we  in  1  writeback write enable.
- wb_rd  in  5  writeback destination index.
- wb_data  in  XLEN  writeback data.
- rs1_data_id  out  XLEN  rs1 read data, driven to ID/EX.
- rs2_data_id  out  XLEN  rs2 read data, driven to ID/EX.
- stall_if_id  out  1  hold the PC and the IF/ID register.
- bubble_id_ex  out  1  zero the ID/EX control fields (insert a NOP).
- stall_count  out  CNT_W  number of load-use stall cycles since reset.

Behaviour:
- Clock and reset: one clock, clk; reset is rst_n, asynchronous, active-low.
- Reset values:
  - All NREGS registers are cleared to 0.
  - stall_count is cleared to 0.
  - Combinational outputs follow their inputs during reset: register reads return 0 and bypass is disabled while rst_n is low.
- Reset mid-operation: asserting rst_n mid-stream clears the registers immediately, without waiting for a clock edge.
- Register x0:
  - Always reads 0.
  - A write with wb_rd = 0 is discarded.
- Write: on a rising edge, if wb_we = 1 and wb_rd != 0, then regs[wb_rd] <= wb_data.
- Read: combinational, zero-cycle latency.
- Bypass (write-first), rs1:
  - If wb_we = 1, wb_rd == rs1_addr_id and rs1_addr_id != 0, then rs1_data_id = wb_data.
  - Otherwise rs1_data_id = regs[rs1_addr_id].
- Bypass, rs2: same rule as rs1 using rs2_addr_id.
- Both ports hit: if both ports address the same register, both return the same value, bypassed or stored.
- Load-use hazard:
  - hazard = load_ex AND (rd_ex != 0) AND ((uses_rs1_id AND rd_ex == rs1_addr_id) OR (uses_rs2_id AND rd_ex == rs2_addr_id)).
  - stall_if_id = hazard and bubble_id_ex = hazard, both combinational in the same cycle.
  - Exactly one stall cycle per load-use pair. On the next cycle the load has moved to MEM and the bubble is in EX with load_ex = 0, so the hazard clears by itself.
- No hazard cases:
  - load_ex = 0, i.e. ALU results; these are handled by EX forwarding, not by this block.
  - rd_ex = 0, including a load to x0.
  - uses_rsN_id = 0 on a matching index, e.g. an LUI whose field bits alias rd_ex.
- stall_count:
  - Increments by 1 on every rising edge where hazard = 1.
  - Saturates at all-ones and does not wrap.
- Simultaneous events: a hazard and a writeback in the same cycle are independent. The write still commits and the bypass still applies.
- No other state, and no valid/ready handshake. The pipeline advances every cycle unless stall_if_id is asserted.

Test Plan:
- Reset and x0:
  - Assert rst_n = 0 mid-run after writing x5 = 0x1234, then release.
  - Required: rs1_data_id and rs2_data_id read 0 for all indices, and stall_count = 0.
  - Write wb_rd = 0, wb_data = 0xFFFFFFFF; required: x0 still reads 0.
- Write then read:
  - Write x7 = 0xDEADBEEF, then on the next cycle read rs1 = 7 and rs2 = 7.
  - Required: both outputs = 0xDEADBEEF.
- Same-cycle bypass:
  - With x3 = 0x11, drive wb_we = 1, wb_rd = 3, wb_data = 0x22 and rs2_addr_id = 3.
  - Required: rs2_data_id = 0x22 in that cycle, and 0x22 from the stored value afterwards.
- Load-use stall:
  - Drive load_ex = 1, rd_ex = 9, rs1_addr_id = 9, uses_rs1_id = 1.
  - Required: stall_if_id = 1 and bubble_id_ex = 1 for one cycle; stall_count goes 0 -> 1.
  - Repeat with rd_ex = 0; required: no stall.
- Hazard qualifiers:
  - Case A: load_ex = 0, rd_ex = 9, rs1_addr_id = 9; required: no stall.
  - Case B: load_ex = 1, rd_ex = 9, rs2_addr_id = 9, uses_rs2_id = 0; required: no stall.
  - Case C: as case B but with uses_rs2_id = 1; required: stall.
- Counter saturation:
  - Force stall_count to 0xFFFFFFFE (or use CNT_W = 4 and hold the hazard for 20 cycles).
  - Required: the counter reaches all-ones and holds there.

Source files
------------

// File: rtl/decode_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_regfile_if
// Purpose  : Bundles the decode-stage register-file signals: source indices
//            and read data, hazard qualifiers from EX, the writeback bus,
//            and the stall/bubble/performance-counter outputs.
// Modports : master - pipeline side (drives indices, writeback, EX info)
//            slave  - decode_regfile side
// Revision : 1.0 - initial release
// ============================================================================
interface decode_regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
);
  localparam int AW = $clog2(NREGS);

  logic [AW-1:0]   rs1_addr_id;
  logic [AW-1:0]   rs2_addr_id;
  logic            uses_rs1_id;
  logic            uses_rs2_id;
  logic [AW-1:0]   rd_ex;
  logic            load_ex;
  logic            wb_we;
  logic [AW-1:0]   wb_rd;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] rs1_data_id;
  logic [XLEN-1:0] rs2_data_id;
  logic            stall_if_id;
  logic            bubble_id_ex;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output rs1_addr_id, rs2_addr_id, uses_rs1_id, uses_rs2_id,
    output rd_ex, load_ex, wb_we, wb_rd, wb_data,
    input  rs1_data_id, rs2_data_id, stall_if_id, bubble_id_ex, stall_count
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, uses_rs1_id, uses_rs2_id,
    input  rd_ex, load_ex, wb_we, wb_rd, wb_data,
    output rs1_data_id, rs2_data_id, stall_if_id, bubble_id_ex, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// Module   : decode_regfile
// Purpose  : Decode-stage register file with write-first bypass from
//            writeback, plus the load-use hazard detector that stalls
//            PC/IF-ID and bubbles ID/EX for one cycle. A saturating counter
//            tallies stall cycles.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - decode_regfile_if.slave (read ports, writeback bus,
//                    EX hazard inputs, stall/bubble/stall_count outputs)
// Revision : 1.0 - initial release
// ============================================================================
module decode_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  decode_regfile_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [CNT_W-1:0] stall_count_q;
  logic             hazard;
  logic             rs1_bypass;
  logic             rs2_bypass;

  // Entry 0 is only ever written by reset, so it stays zero; the read muxes
  // also force index 0 to zero explicitly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.wb_we && (bus.wb_rd != '0)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Write-first bypass; disabled while in reset so reads return the
  // (cleared) stored contents.
  assign rs1_bypass = rst_n && bus.wb_we && (bus.wb_rd == bus.rs1_addr_id)
                      && (bus.rs1_addr_id != '0);
  assign rs2_bypass = rst_n && bus.wb_we && (bus.wb_rd == bus.rs2_addr_id)
                      && (bus.rs2_addr_id != '0);

  assign bus.rs1_data_id = rs1_bypass                  ? bus.wb_data :
                           (bus.rs1_addr_id == AW'(0)) ? '0 : regs[bus.rs1_addr_id];
  assign bus.rs2_data_id = rs2_bypass                  ? bus.wb_data :
                           (bus.rs2_addr_id == AW'(0)) ? '0 : regs[bus.rs2_addr_id];

  // Only loads need a stall; ALU results reach ID/EX consumers through
  // EX forwarding. The uses_* qualifiers keep immediate-form fields that
  // happen to alias rd_ex from causing false stalls.
  assign hazard = bus.load_ex && (bus.rd_ex != '0) &&
                  ((bus.uses_rs1_id && (bus.rd_ex == bus.rs1_addr_id)) ||
                   (bus.uses_rs2_id && (bus.rd_ex == bus.rs2_addr_id)));

  assign bus.stall_if_id  = hazard;
  assign bus.bubble_id_ex = hazard;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else if (hazard && (stall_count_q != '1)) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_regfile
// Purpose  : Directed bench for decode_regfile; expectations are queued as
//            stimulus is applied and compared once outputs settle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_regfile;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam int S_RS1 = 0;
  localparam int S_RS2 = 1;
  localparam int S_STL = 2;
  localparam int S_BUB = 3;
  localparam int S_CNT = 4;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   exp_cnt = 0;

  decode_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) bus ();

  decode_regfile #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RS1:   return bus.rs1_data_id;
      S_RS2:   return bus.rs2_data_id;
      S_STL:   return 32'(bus.stall_if_id);
      S_BUB:   return 32'(bus.bubble_id_ex);
      default: return 32'(bus.stall_count);
    endcase
  endfunction

  // Let combinational outputs settle, then retire every queued expectation.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.val) passed++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hz(input logic ld, input logic [4:0] rd, input logic [4:0] a1,
                    input logic u1, input logic [4:0] a2, input logic u2);
    bus.load_ex     = ld;
    bus.rd_ex       = rd;
    bus.rs1_addr_id = a1;
    bus.uses_rs1_id = u1;
    bus.rs2_addr_id = a2;
    bus.uses_rs2_id = u2;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_we   = we;
    bus.wb_rd   = rd;
    bus.wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    hz(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    step();
    push("reset_count", S_CNT, 32'h0);
    push("reset_stall", S_STL, 32'h0);
    drain();
    rst_n = 1'b1;
    step();

    // Populate x5 and bump the counter so the mid-run reset has work to undo.
    wb(1'b1, 5'd5, 32'h1234);
    step();
    wb(1'b0, 5'd0, 32'h0);
    hz(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    push("x5_written", S_RS1, 32'h1234);
    push("pre_rst_stall", S_STL, 32'h1);
    drain();
    step();
    hz(1'b0, 5'd0, 5'd5, 1'b0, 5'd5, 1'b0);
    push("pre_rst_count", S_CNT, 32'h1);
    drain();

    // Asynchronous reset between edges; bypass must be suppressed too.
    #1 rst_n = 1'b0;
    wb(1'b1, 5'd5, 32'hAAAA_5555);
    push("async_rst_rs1", S_RS1, 32'h0);
    push("rst_no_bypass", S_RS2, 32'h0);
    push("async_rst_cnt", S_CNT, 32'h0);
    drain();
    step();
    rst_n = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < NREGS; i++) begin
      hz(1'b0, 5'd0, 5'(i), 1'b0, 5'(i), 1'b0);
      push("post_rst_rs1", S_RS1, 32'h0);
      push("post_rst_rs2", S_RS2, 32'h0);
      drain();
    end
    push("post_rst_count", S_CNT, 32'h0);
    drain();
    exp_cnt = 0;

    // x0 write must be discarded and never bypassed.
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    hz(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    push("x0_no_bypass", S_RS1, 32'h0);
    drain();
    step();
    wb(1'b0, 5'd0, 32'h0);
    push("x0_stored", S_RS1, 32'h0);
    drain();

    // Write then read on both ports.
    wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    step();
    wb(1'b0, 5'd0, 32'h0);
    hz(1'b0, 5'd0, 5'd7, 1'b0, 5'd7, 1'b0);
    push("x7_rs1", S_RS1, 32'hDEAD_BEEF);
    push("x7_rs2", S_RS2, 32'hDEAD_BEEF);
    drain();

    // Same-cycle bypass over a stale stored value.
    wb(1'b1, 5'd3, 32'h11);
    step();
    wb(1'b1, 5'd3, 32'h22);
    hz(1'b0, 5'd0, 5'd3, 1'b0, 5'd3, 1'b0);
    push("bypass_rs2", S_RS2, 32'h22);
    push("bypass_rs1", S_RS1, 32'h22);
    drain();
    step();
    wb(1'b0, 5'd0, 32'h0);
    push("x3_stored", S_RS2, 32'h22);
    drain();

    // Load-use on rs1, with a concurrent writeback to the same register.
    hz(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    wb(1'b1, 5'd9, 32'h99);
    push("lu_stall", S_STL, 32'h1);
    push("lu_bubble", S_BUB, 32'h1);
    push("lu_cnt_before", S_CNT, 32'h0);
    push("lu_bypass", S_RS1, 32'h99);
    drain();
    step();
    exp_cnt = 1;
    wb(1'b0, 5'd0, 32'h0);
    hz(1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0);
    push("lu_clears", S_STL, 32'h0);
    push("lu_cnt_after", S_CNT, 32'(exp_cnt));
    push("lu_wb_commit", S_RS1, 32'h99);
    drain();

    // Load to x0 never stalls.
    hz(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    push("rd0_stall", S_STL, 32'h0);
    drain();
    step();
    push("rd0_count", S_CNT, 32'(exp_cnt));
    drain();

    // Qualifiers: non-load, unused operand, then used operand.
    hz(1'b0, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    push("caseA_stall", S_STL, 32'h0);
    drain();
    hz(1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
    push("caseB_stall", S_STL, 32'h0);
    push("caseB_bubble", S_BUB, 32'h0);
    drain();
    hz(1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b1);
    push("caseC_stall", S_STL, 32'h1);
    push("caseC_bubble", S_BUB, 32'h1);
    drain();
    step();
    exp_cnt = exp_cnt + 1;
    hz(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    push("caseC_count", S_CNT, 32'(exp_cnt));
    drain();

    // Hold a hazard well past the counter range; it must stick at all-ones.
    hz(1'b1, 5'd12, 5'd0, 1'b0, 5'd12, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_cnt < CMAX) exp_cnt = exp_cnt + 1;
      push("sat_count", S_CNT, 32'(exp_cnt));
      drain();
    end
    hz(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    step();
    push("sat_hold", S_CNT, 32'(CMAX));
    push("sat_no_stall", S_STL, 32'h0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire
